// File: rtl/md_hilo_ctrl_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide
// sequencer: operation request, MT/MF access and HI/LO status.
interface md_hilo_ctrl_if;
    logic        MdStartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        HiLoWriteE;
    logic        HiLoE;
    logic        HiLoReadE;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        MdBusy;
    logic        MdDone;
    logic        MdStallE;

    modport master (
        output MdStartE, MdOpE, SrcAE, SrcBE,
        output HiLoWriteE, HiLoE, HiLoReadE,
        input  Hi, Lo, MdBusy, MdDone, MdStallE
    );

    modport slave (
        input  MdStartE, MdOpE, SrcAE, SrcBE,
        input  HiLoWriteE, HiLoE, HiLoReadE,
        output Hi, Lo, MdBusy, MdDone, MdStallE
    );
endinterface

// File: rtl/md_hilo_ctrl.sv
// Iterative 32-step multiply / restoring divide sequencer that owns
// the HI/LO pair and raises the EX stall while an operation runs.
module md_hilo_ctrl #(
    parameter int ITER = 32
) (
    input  logic          clk,
    input  logic          rst,
    md_hilo_ctrl_if.slave md_if
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_t;

    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_div;
    logic [63:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_psign;
    logic        r_rsign;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_signed;
    logic        w_is_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_madd;
    logic [63:0] w_mstep;
    logic [32:0] w_shl;
    logic [32:0] w_sub;
    logic [63:0] w_dstep;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_dz;

    assign w_signed = r_op[0];
    assign w_is_div = r_op[1];
    assign w_neg_a  = w_signed & r_a[31];
    assign w_neg_b  = w_signed & r_b[31];
    assign w_abs_a  = w_neg_a ? (32'd0 - r_a) : r_a;
    assign w_abs_b  = w_neg_b ? (32'd0 - r_b) : r_b;

    // Multiply: upper half accumulates, multiplier shifts out of the low half
    assign w_madd  = {1'b0, r_acc[63:32]}
                   + {1'b0, (r_acc[0] ? r_div : 32'd0)};
    assign w_mstep = {w_madd, r_acc[31:1]};

    // Divide: upper half is the partial remainder, low half the quotient
    assign w_shl   = {r_acc[63:32], r_acc[31]};
    assign w_sub   = w_shl - {1'b0, r_div};
    assign w_dstep = w_sub[32] ? {w_shl[31:0], r_acc[30:0], 1'b0}
                               : {w_sub[31:0], r_acc[30:0], 1'b1};

    assign w_prod = r_psign ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = r_psign ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_rsign ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_dz   = (r_b == 32'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_div   <= 32'd0;
            r_acc   <= 64'd0;
            r_cnt   <= 5'd0;
            r_psign <= 1'b0;
            r_rsign <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (md_if.MdStartE) begin
                        r_op    <= md_if.MdOpE;
                        r_a     <= md_if.SrcAE;
                        r_b     <= md_if.SrcBE;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end else if (md_if.HiLoWriteE) begin
                        if (md_if.HiLoE) r_hi <= md_if.SrcAE;
                        else             r_lo <= md_if.SrcAE;
                    end
                end
                S_PREP: begin
                    r_psign <= w_neg_a ^ w_neg_b;
                    r_rsign <= w_neg_a;
                    r_cnt   <= 5'd0;
                    if (w_is_div) begin
                        r_acc <= {32'd0, w_abs_a};
                        r_div <= w_abs_b;
                    end else begin
                        r_acc <= {32'd0, w_abs_b};
                        r_div <= w_abs_a;
                    end
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_dstep : w_mstep;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!w_is_div) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (w_dz) begin
                        r_hi <= r_a;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md_if.Hi       = r_hi;
    assign md_if.Lo       = r_lo;
    assign md_if.MdBusy   = r_busy;
    assign md_if.MdDone   = r_done;
    assign md_if.MdStallE = r_busy & (md_if.MdStartE | md_if.HiLoWriteE
                                      | md_if.HiLoReadE);
endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Scoreboard bench for md_hilo_ctrl: random and directed MULT/DIV/MT
// traffic against a plain-arithmetic reference of the HI/LO results.
module tb_md_hilo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    md_hilo_ctrl_if bus();

    md_hilo_ctrl #(.ITER(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .md_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    int          busy_len = 0;
    logic [31:0] m_hi     = 32'd0;
    logic [31:0] m_lo     = 32'd0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(logic [1:0] op, logic [31:0] a,
                                   logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      la, lb, q, r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        e.tag = $sformatf("op%0d %h,%h", op, a, b);
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            2'd1: begin
                p = 64'(la * lb);
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    e.hi = a % b; e.lo = a / b;
                end else begin
                    q = la / lb; r = la % lb;
                    e.hi = 32'(r); e.lo = 32'(q);
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Result monitor: every MdDone pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.MdDone) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got hi %h lo %h expected none",
                         bus.Hi, bus.Lo);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, " HI"}, bus.Hi, mon_e.hi);
                chk({mon_e.tag, " LO"}, bus.Lo, mon_e.lo);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) busy_len = 0;
        else if (bus.MdBusy) busy_len++;
        else if (busy_len != 0) begin
            chk("busy_len", 32'(busy_len), 32'd34);
            busy_len = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.MdBusy && n < 60) begin
            @(negedge clk); n++;
        end
        if (bus.MdBusy) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got busy 1 expected 0");
        end
    endtask

    task automatic run_op(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                          exp_t e);
        @(negedge clk);
        bus.MdStartE = 1'b1; bus.MdOpE = op;
        bus.SrcAE = a; bus.SrcBE = b;
        sb.push_back(e);
        @(negedge clk);
        bus.MdStartE = 1'b0;
        bus.SrcAE = $urandom; bus.SrcBE = $urandom;
        wait_idle();
        m_hi = e.hi; m_lo = e.lo;
    endtask

    task automatic run_dir(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                           logic [31:0] hi, logic [31:0] lo);
        exp_t e;
        e.hi = hi; e.lo = lo;
        e.tag = $sformatf("dir op%0d %h,%h", op, a, b);
        run_op(op, a, b, e);
    endtask

    task automatic mt(logic sel, logic [31:0] val);
        @(negedge clk);
        bus.HiLoWriteE = 1'b1; bus.HiLoE = sel; bus.SrcAE = val;
        #1;
        chk("mt_no_bypass", sel ? bus.Hi : bus.Lo, sel ? m_hi : m_lo);
        @(negedge clk);
        bus.HiLoWriteE = 1'b0;
        if (sel) m_hi = val; else m_lo = val;
        chk("mt_hi", bus.Hi, m_hi);
        chk("mt_lo", bus.Lo, m_lo);
    endtask

    initial begin
        int   k;
        int   d0;
        logic [1:0]  op;
        logic [31:0] a, b;
        exp_t e;

        bus.MdStartE = 1'b0; bus.MdOpE = 2'd0;
        bus.SrcAE = 32'd0; bus.SrcBE = 32'd0;
        bus.HiLoWriteE = 1'b0; bus.HiLoE = 1'b0; bus.HiLoReadE = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", bus.Hi, 32'd0);
        chk("rst_lo", bus.Lo, 32'd0);
        chk("rst_busy", 32'(bus.MdBusy), 32'd0);
        chk("rst_done", 32'(bus.MdDone), 32'd0);
        chk("rst_stall", 32'(bus.MdStallE), 32'd0);

        run_dir(2'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_dir(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
        run_dir(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
        run_dir(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_dir(2'd2, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_dir(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        mt(1'b1, 32'hCAFE_0001);
        mt(1'b0, 32'hCAFE_0002);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mt(1'($urandom_range(0, 1)), $urandom);
            end else begin
                op = 2'($urandom_range(0, 3));
                a = pick(); b = pick();
                run_op(op, a, b, model(op, a, b));
                chk("mf_hi", bus.Hi, m_hi);
                chk("mf_lo", bus.Lo, m_lo);
            end
        end

        // MTHI held from cycle 10 of a DIVU 100 / 7
        run_dir(2'd0, 32'd1, 32'd1, 32'd0, 32'd1);
        @(negedge clk);
        bus.MdStartE = 1'b1; bus.MdOpE = 2'd2;
        bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
        e.hi = 32'd2; e.lo = 32'd14; e.tag = "divu100_7";
        sb.push_back(e);
        @(negedge clk);
        bus.MdStartE = 1'b0;
        repeat (9) @(negedge clk);
        bus.HiLoWriteE = 1'b1; bus.HiLoE = 1'b1; bus.SrcAE = 32'h1234_5678;
        #1;
        k = 0;
        while (bus.MdBusy && k < 60) begin
            chk("mthi_stall", 32'(bus.MdStallE), 32'd1);
            @(negedge clk); #1; k++;
        end
        chk("mthi_idle_stall", 32'(bus.MdStallE), 32'd0);
        chk("mthi_pre_hi", bus.Hi, 32'd2);
        @(negedge clk);
        bus.HiLoWriteE = 1'b0;
        chk("mthi_post_hi", bus.Hi, 32'h1234_5678);
        chk("mthi_post_lo", bus.Lo, 32'd14);
        m_hi = 32'h1234_5678; m_lo = 32'd14;

        // MFLO held through a DIVU 1000 / 9, with a stray second start
        @(negedge clk);
        bus.MdStartE = 1'b1; bus.MdOpE = 2'd2;
        bus.SrcAE = 32'd1000; bus.SrcBE = 32'd9;
        e.hi = 32'd1; e.lo = 32'd111; e.tag = "divu1000_9";
        sb.push_back(e);
        k = 0;
        while (k < 60) begin
            @(negedge clk);
            bus.MdStartE = (k == 4);
            bus.HiLoReadE = 1'b1;
            if (k == 4) begin
                bus.MdOpE = 2'd0; bus.SrcAE = 32'd3; bus.SrcBE = 32'd3;
            end
            #1;
            if (!bus.MdBusy) break;
            chk("mflo_stall", 32'(bus.MdStallE), 32'd1);
            k++;
        end
        chk("mflo_idle_stall", 32'(bus.MdStallE), 32'd0);
        chk("mflo_lo", bus.Lo, 32'd111);
        @(negedge clk);
        bus.HiLoReadE = 1'b0;
        chk("no_restart_busy", 32'(bus.MdBusy), 32'd0);
        m_hi = 32'd1; m_lo = 32'd111;

        // Asynchronous reset in the middle of a MULT
        @(negedge clk);
        bus.MdStartE = 1'b1; bus.MdOpE = 2'd1;
        bus.SrcAE = 32'h0001_2345; bus.SrcBE = 32'hFFFF_0010;
        sb.push_back(model(2'd1, 32'h0001_2345, 32'hFFFF_0010));
        @(negedge clk);
        bus.MdStartE = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_hi", bus.Hi, 32'd0);
        chk("arst_lo", bus.Lo, 32'd0);
        chk("arst_busy", 32'(bus.MdBusy), 32'd0);
        if (sb.size() > 0) void'(sb.pop_front());
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_no_done", 32'(done_cnt), 32'(d0));
        m_hi = 32'd0; m_lo = 32'd0;
        run_dir(2'd0, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
